fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Instruction fetch stage for the Cortex-M0 core.
- Owns the fetch PC and drives the address and lane-select inputs of the program ROM. The ROM returns two halfwords per cycle and interleaves them across its two banks: even halfwords live in bank 0, odd halfwords in bank 1.
- Captures both returned halfwords into a small in-order halfword queue.
- Presents up to two instructions per cycle to decode, and supports branch redirect with a full flush.

Parameters:
- QDEPTH, 4: queue depth in 16-bit entries. Power of two, at least 4.
- RESET_PC, 15'h0000: halfword fetch address loaded at reset.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- rom_addr  out  14  ROM word address = fetch_pc[14:1]
- rom_pc_1  out  1  = fetch_pc[0]
- rom_sel_mem_1  out  1  even PC: 1; odd PC: 0
- rom_sel_mem_0  out  2  even PC: 2'd0; odd PC: 2'd2. Value 2'd1 is never driven.
- rom_ir_0  in  16  ROM halfword at fetch_pc
- rom_ir_1  in  16  ROM halfword at fetch_pc+1
- redirect_valid  in  1  branch or exception redirect
- redirect_pc  in  15  halfword target address
- dec_take  in  2  entries consumed by decode this cycle (0..2)
- dec_count  out  3  valid entries in the queue (0..QDEPTH)
- dec_instr_0  out  16  head entry
- dec_instr_1  out  16  head+1 entry
- dec_pc_0  out  15  halfword address of the head entry

Behaviour:
- ROM interface
  - All ROM outputs are combinational from the fetch_pc register.
  - The ROM is combinational, so rom_ir_0 and rom_ir_1 are valid in the same cycle.
- Reset (asynchronous, rst_n low)
  - fetch_pc=RESET_PC, head=0, tail=0, count=0.
  - dec_count=0, dec_instr_0/1=16'h0000, dec_pc_0=RESET_PC.
- Effective take
  - take_eff = min(dec_take, count).
  - An over-take is clamped and never underflows the queue.
- Fetch enable
  - fetch_en = (QDEPTH - count + take_eff >= 2) and not redirect_valid.
  - Free space includes entries being consumed in the same cycle.
- On fetch_en
  - Write rom_ir_0 at tail and rom_ir_1 at tail+1.
  - tail += 2; fetch_pc += 2, wrapping modulo 2^15.
- Count update: count_next = count - take_eff + 2*fetch_en.
- Pointer wrap: head and tail wrap modulo QDEPTH.
- Head PC tracking
  - A head PC register advances by take_eff each cycle.
  - When the queue is empty and a fetch occurs, the head PC is loaded from fetch_pc.
- Output latency
  - Queue outputs are registered.
  - A halfword fetched in cycle N is visible at dec_instr_* in cycle N+1.
- Redirect (highest priority)
  - Flush: count=0, head=tail=0.
  - fetch_pc=redirect_pc and head PC=redirect_pc.
  - dec_take and the fetch are ignored that cycle.
  - The first fetch from the target happens in the next cycle.
  - The target instruction is visible to decode 2 cycles after the redirect.
- Odd redirect_pc: the selects flip to odd mode. Queue order is always ascending halfword address, regardless of bank.
- dec_instr_1 validity: meaningful only when dec_count >= 2. The value is don't-care otherwise.
- Redirect while the queue is full: the flush takes effect, with no stall.
- Steady state, QDEPTH=4, decode taking 2 per cycle: one fetch per cycle; count stays at 2 after warm-up.

Optional Feature:
- Macro: FETCH_EMPTY_CNT_EN
- When defined, adds output port fetch_empty_cnt (16 bits).
  - Saturating count of cycles with count==0 while not in reset.
  - Cleared to 0 by reset.
  - Holds at 16'hFFFF once reached.
  - Not cleared by redirect.
- When undefined: the port and its counter are absent, and all other behaviour is identical.

Test Plan:
- Reset check
  - Stimulus: RESET_PC=0, ROM halfwords 0..3 = 2002, 2105, 2209, 1800; release reset; dec_take=0.
  - Required:
    - rom_addr=0, rom_sel_mem_1=1, rom_sel_mem_0=0.
    - Cycle 1: dec_count=2, instr_0=2002, instr_1=2105, pc_0=0.
    - Cycle 2: dec_count=4, then fetch stalls with fetch_pc=4.
- Full queue, take 1
  - Stimulus: queue full, dec_take=1.
  - Required: no fetch (free=1); next cycle count=3, instr_0=2105, pc_0=1.
- Redirect to odd address
  - Stimulus: redirect_valid with redirect_pc=1 while full.
  - Required:
    - Next cycle: count=0, rom_addr=0, rom_pc_1=1, sel_mem_1=0, sel_mem_0=2.
    - Following cycle: instr_0=2105, instr_1=2209, pc_0=1.
- Redirect priority
  - Stimulus: redirect_valid plus dec_take=2 plus free space, all in the same cycle.
  - Required: the take and the fetch are ignored; count=0 the next cycle.
- Streaming and wrap
  - Stimulus: dec_take=2 every cycle from reset.
  - Required: count settles at 2; pc_0 steps 0, 2, 4, ...; fetch_pc wraps from 7FFE to 0000.
- Empty counter (FETCH_EMPTY_CNT_EN)
  - Stimulus: over-take (dec_take=2 with count=1) followed by redirects held for 5 cycles.
  - Required: no underflow (count=0); fetch_empty_cnt increments by 1 per empty cycle.

Source files
------------

// File: rtl/fetch_queue_if.sv
// fetch_queue_if: ROM and decode bus of the instruction fetch stage.
//   master: fetch side (drives ROM address/selects and decode outputs)
//   slave : environment side (ROM data, redirect, decode take)
//   rom_addr/rom_pc_1/rom_sel_mem_1/rom_sel_mem_0 : ROM address and bank selects
//   rom_ir_0/rom_ir_1   : halfwords at fetch_pc and fetch_pc+1
//   redirect_valid/pc   : branch/exception redirect
//   dec_take            : entries consumed by decode (0..2)
//   dec_count/instr/pc  : queue state presented to decode
interface fetch_queue_if;
  logic [13:0] rom_addr;
  logic        rom_pc_1;
  logic        rom_sel_mem_1;
  logic [1:0]  rom_sel_mem_0;
  logic [15:0] rom_ir_0;
  logic [15:0] rom_ir_1;
  logic        redirect_valid;
  logic [14:0] redirect_pc;
  logic [1:0]  dec_take;
  logic [2:0]  dec_count;
  logic [15:0] dec_instr_0;
  logic [15:0] dec_instr_1;
  logic [14:0] dec_pc_0;

  modport master (
    output rom_addr, rom_pc_1, rom_sel_mem_1, rom_sel_mem_0,
    output dec_count, dec_instr_0, dec_instr_1, dec_pc_0,
    input  rom_ir_0, rom_ir_1, redirect_valid, redirect_pc, dec_take
  );

  modport slave (
    input  rom_addr, rom_pc_1, rom_sel_mem_1, rom_sel_mem_0,
    input  dec_count, dec_instr_0, dec_instr_1, dec_pc_0,
    output rom_ir_0, rom_ir_1, redirect_valid, redirect_pc, dec_take
  );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch stage. Owns the halfword fetch PC, drives the
// banked program ROM, and buffers returned halfwords in an in-order queue of
// QDEPTH 16-bit entries presented to decode (up to two per cycle).
// Ports:
//   clk, rst_n : core clock, asynchronous active-low reset
//   bus        : fetch_queue_if.master (ROM interface + decode interface)
//   fetch_empty_cnt (only with FETCH_EMPTY_CNT_EN defined): saturating count
//                of cycles spent with an empty queue
// Optional feature macro: FETCH_EMPTY_CNT_EN
module fetch_queue #(
  parameter int          QDEPTH   = 4,
  parameter logic [14:0] RESET_PC = 15'h0000
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_queue_if.master bus
`ifdef FETCH_EMPTY_CNT_EN
  ,
  output logic [15:0]   fetch_empty_cnt
`endif
);
  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;

  logic [14:0]              fetch_pc, head_pc;
  logic [PW-1:0]            head, tail;
  logic [CW-1:0]            count, take_eff;
  logic [CW:0]              space;
  logic                     fetch_en;
  logic [QDEPTH-1:0][15:0]  mem;

  // Free space counts entries decode drains this same cycle.
  always_comb begin
    take_eff = (CW'(bus.dec_take) > count) ? count : CW'(bus.dec_take);
    space    = (CW+1)'(QDEPTH) - {1'b0, count} + {1'b0, take_eff};
    fetch_en = (space >= (CW+1)'(2)) && !bus.redirect_valid;
  end

  // ROM is addressed straight from the PC register; bank selects follow parity.
  assign bus.rom_addr      = fetch_pc[14:1];
  assign bus.rom_pc_1      = fetch_pc[0];
  assign bus.rom_sel_mem_1 = ~fetch_pc[0];
  assign bus.rom_sel_mem_0 = fetch_pc[0] ? 2'd2 : 2'd0;

  assign bus.dec_count   = 3'(count);
  assign bus.dec_instr_0 = mem[head];
  assign bus.dec_instr_1 = mem[head + PW'(1)];
  assign bus.dec_pc_0    = head_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      head_pc  <= RESET_PC;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      mem      <= '0;
    end else if (bus.redirect_valid) begin
      // Flush; take and fetch are both dropped this cycle.
      fetch_pc <= bus.redirect_pc;
      head_pc  <= bus.redirect_pc;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else begin
      head  <= head + PW'(take_eff);
      count <= count - take_eff + (fetch_en ? CW'(2) : CW'(0));
      // An empty queue has no head entry to track; the next one fetched is fetch_pc.
      if (fetch_en && count == '0) head_pc <= fetch_pc;
      else                         head_pc <= head_pc + 15'(take_eff);
      if (fetch_en) begin
        mem[tail]          <= bus.rom_ir_0;
        mem[tail + PW'(1)] <= bus.rom_ir_1;
        tail               <= tail + PW'(2);
        fetch_pc           <= fetch_pc + 15'd2;
      end
    end
  end

`ifdef FETCH_EMPTY_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                        fetch_empty_cnt <= '0;
    else if (count == '0 && fetch_empty_cnt != 16'hFFFF) fetch_empty_cnt <= fetch_empty_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: randomized + directed stimulus against a queue-level
// reference model; expectations go into a scoreboard that a negedge monitor
// drains and compares against the DUT.
module tb_fetch_queue;
  localparam int QDEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_queue_if bus();
`ifdef FETCH_EMPTY_CNT_EN
  logic [15:0] fetch_empty_cnt;
`endif

  fetch_queue #(.QDEPTH(QDEPTH), .RESET_PC(15'h0000)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
`ifdef FETCH_EMPTY_CNT_EN
    ,
    .fetch_empty_cnt(fetch_empty_cnt)
`endif
  );

  // Program ROM contents by halfword address.
  function automatic logic [15:0] rom_hw(input logic [14:0] a);
    logic [15:0] t;
    case (a)
      15'd0: return 16'h2002;
      15'd1: return 16'h2105;
      15'd2: return 16'h2209;
      15'd3: return 16'h1800;
      default: begin
        t = {1'b0, a};
        return (t * 16'h9E37) ^ 16'h5A5A;
      end
    endcase
  endfunction

  logic [14:0] rom_pc;
  assign rom_pc       = {bus.rom_addr, bus.rom_pc_1};
  assign bus.rom_ir_0 = rom_hw(rom_pc);
  assign bus.rom_ir_1 = rom_hw(rom_pc + 15'd1);

  typedef struct {
    logic [14:0] pc;
    logic [15:0] hw;
  } ent_t;

  typedef struct {
    int          cnt;
    logic [15:0] i0, i1;
    logic [14:0] pc0, fpc;
    int          ecnt;
  } exp_t;

  ent_t mq[$];
  exp_t sbq[$];
  logic [14:0] mfpc;
  int mecnt;
  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Queue-level reference: pop what decode takes, append a halfword pair if
  // two slots are free, redirect empties everything.
  task automatic model_step(input int take, input bit rv, input logic [14:0] rpc);
    int te;
    exp_t e;
    if (mq.size() == 0 && mecnt < 65535) mecnt++;
    if (rv) begin
      mq.delete();
      mfpc = rpc;
    end else begin
      te = (take < mq.size()) ? take : mq.size();
      repeat (te) void'(mq.pop_front());
      if (QDEPTH - mq.size() >= 2) begin
        mq.push_back('{pc: mfpc, hw: rom_hw(mfpc)});
        mq.push_back('{pc: mfpc + 15'd1, hw: rom_hw(mfpc + 15'd1)});
        mfpc = mfpc + 15'd2;
      end
    end
    e.cnt  = mq.size();
    e.pc0  = (mq.size() > 0) ? mq[0].pc : mfpc;
    e.i0   = (mq.size() > 0) ? mq[0].hw : 16'h0;
    e.i1   = (mq.size() > 1) ? mq[1].hw : 16'h0;
    e.fpc  = mfpc;
    e.ecnt = mecnt;
    sbq.push_back(e);
  endtask

  task automatic cycle(input int take, input bit rv, input logic [14:0] rpc);
    bus.dec_take       = 2'(take);
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    @(posedge clk);
    model_step(take, rv, rpc);
    @(negedge clk);
    #1;
  endtask

  // Monitor: compares DUT state against the oldest expectation each cycle.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("dec_count", 32'(bus.dec_count), 32'(e.cnt));
      chk("dec_pc_0", 32'(bus.dec_pc_0), 32'(e.pc0));
      if (e.cnt >= 1) chk("dec_instr_0", 32'(bus.dec_instr_0), 32'(e.i0));
      if (e.cnt >= 2) chk("dec_instr_1", 32'(bus.dec_instr_1), 32'(e.i1));
      chk("rom_addr", 32'(bus.rom_addr), 32'(e.fpc[14:1]));
      chk("rom_pc_1", 32'(bus.rom_pc_1), 32'(e.fpc[0]));
      chk("rom_sel_mem_1", 32'(bus.rom_sel_mem_1), 32'(!e.fpc[0]));
      chk("rom_sel_mem_0", 32'(bus.rom_sel_mem_0), e.fpc[0] ? 32'd2 : 32'd0);
`ifdef FETCH_EMPTY_CNT_EN
      chk("fetch_empty_cnt", 32'(fetch_empty_cnt), 32'(e.ecnt));
`endif
    end
  end

  initial begin
    bus.dec_take       = 2'd0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 15'h0;
    mfpc  = 15'h0000;
    mecnt = 0;
    repeat (2) @(negedge clk);
    // Reset state
    chk("rst_dec_count", 32'(bus.dec_count), 32'd0);
    chk("rst_instr_0", 32'(bus.dec_instr_0), 32'h0);
    chk("rst_instr_1", 32'(bus.dec_instr_1), 32'h0);
    chk("rst_pc_0", 32'(bus.dec_pc_0), 32'h0);
    chk("rst_rom_addr", 32'(bus.rom_addr), 32'h0);
    chk("rst_sel_mem_1", 32'(bus.rom_sel_mem_1), 32'd1);
    chk("rst_sel_mem_0", 32'(bus.rom_sel_mem_0), 32'd0);
`ifdef FETCH_EMPTY_CNT_EN
    chk("rst_empty_cnt", 32'(fetch_empty_cnt), 32'd0);
`endif
    #1 rst_n = 1'b1;

    // Fill with no take, then stall when full.
    repeat (4) cycle(0, 1'b0, 15'h0);
    // Full queue, take 1: no fetch.
    cycle(1, 1'b0, 15'h0);
    cycle(0, 1'b0, 15'h0);
    // Redirect to odd address while full.
    cycle(0, 1'b1, 15'h0001);
    repeat (2) cycle(0, 1'b0, 15'h0);
    // Redirect priority over take and available fetch.
    cycle(1, 1'b0, 15'h0);
    cycle(2, 1'b1, 15'h0010);
    // Over-take on an empty queue is clamped.
    cycle(2, 1'b0, 15'h0);
    // Held redirects keep the queue empty.
    repeat (5) cycle(2, 1'b1, 15'h0020);
    // Streaming take-2 across the PC wrap.
    cycle(0, 1'b1, 15'h7FFA);
    repeat (8) cycle(2, 1'b0, 15'h0);
    // Odd-aligned streaming across the wrap.
    cycle(0, 1'b1, 15'h7FFB);
    repeat (6) cycle(2, 1'b0, 15'h0);

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      bit          rv;
      logic [14:0] rpc;
      rv  = ($urandom_range(0, 11) == 0);
      rpc = ($urandom_range(0, 3) == 0) ? 15'(15'h7FF8 + 15'($urandom_range(0, 7)))
                                        : 15'($urandom);
      cycle(int'($urandom_range(0, 2)), rv, rpc);
    end
    bus.redirect_valid = 1'b0;
    bus.dec_take       = 2'd0;

    repeat (2) @(negedge clk);
    tests++;
    if (sbq.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
